alu_client: RTL and testbench

ALU_CLIENT -- requirements
Module: alu_client

---
 rtl/alu_client_pkg.sv | 26 ++
 rtl/alu_client_tick_timer.sv | 37 +++
 rtl/alu_client.sv | 142 ++++++++++++++
 tb/tb_alu_client.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_client_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_client_pkg                                         |
// | Description : Shared state encoding and timeout default for the      |
// |               host end of the 3-byte ALU link.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_client_pkg;

  // Default number of baud ticks to wait for the result byte
  localparam logic [15:0] c_TIMEOUT_TICKS_DEFAULT = 16'd40000;

  // One-hot state encoding; any other value is treated as illegal
  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_SEND_A   = 8'b0000_0010,
    ST_WAIT_A   = 8'b0000_0100,
    ST_SEND_B   = 8'b0000_1000,
    ST_WAIT_B   = 8'b0001_0000,
    ST_SEND_OP  = 8'b0010_0000,
    ST_WAIT_OP  = 8'b0100_0000,
    ST_WAIT_RES = 8'b1000_0000
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_client_tick_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_client_tick_timer                                  |
// | Description : Saturating tick counter with clear and enable; flags   |
// |               expiry once TIMEOUT_TICKS ticks have been counted.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_client_tick_timer
  import alu_client_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_TICKS = c_TIMEOUT_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic expired
);

  logic [15:0] r_count;

  // Count ticks while enabled, holding at the limit; clear has priority
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && tick && (r_count != TIMEOUT_TICKS)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign expired = (r_count == TIMEOUT_TICKS);

endmodule
`default_nettype wire

// File: rtl/alu_client.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_client                                             |
// | Description : Host end of the 3-byte UART ALU link. Sends operand A, |
// |               operand B and opcode, then waits for one result byte   |
// |               or gives up after TIMEOUT_TICKS baud ticks.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_client
  import alu_client_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_TICKS = c_TIMEOUT_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [7:0] req_op,
  output logic       req_ready,
  output logic [7:0] to_tx,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic [7:0] from_rx,
  input  logic       tick,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout,
  output logic       busy
);

  state_t     r_state;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  logic [7:0] r_op_code;
  logic       w_in_wait_res;
  logic       w_expired;

  // Timer only runs while waiting for the result; it is held clear
  // everywhere else so it always starts from zero on entry.
  assign w_in_wait_res = (r_state == ST_WAIT_RES);

  alu_client_tick_timer #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_tick_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_in_wait_res),
    .enable  (w_in_wait_res),
    .tick    (tick),
    .expired (w_expired)
  );

  // Link sequencer: every output is loaded on the transition into the
  // state that owns it, so pulses line up with SEND/response states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_code    <= '0;
      to_tx        <= '0;
      tx_start     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_timeout <= 1'b0;
      busy         <= 1'b0;
      req_ready    <= 1'b1;
    end else begin
      tx_start     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            r_op_a    <= req_a;
            r_op_b    <= req_b;
            r_op_code <= req_op;
            to_tx     <= req_a;
            tx_start  <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= ST_SEND_A;
          end
        end
        ST_SEND_A: begin
          // keep to_tx pinned to the latched operand for the whole byte
          to_tx   <= r_op_a;
          r_state <= ST_WAIT_A;
        end
        ST_WAIT_A: begin
          if (tx_done) begin
            to_tx    <= r_op_b;
            tx_start <= 1'b1;
            r_state  <= ST_SEND_B;
          end
        end
        ST_SEND_B: begin
          r_state <= ST_WAIT_B;
        end
        ST_WAIT_B: begin
          if (tx_done) begin
            to_tx    <= r_op_code;
            tx_start <= 1'b1;
            r_state  <= ST_SEND_OP;
          end
        end
        ST_SEND_OP: begin
          r_state <= ST_WAIT_OP;
        end
        ST_WAIT_OP: begin
          if (tx_done) begin
            r_state <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          // a result byte beats a simultaneous timeout
          if (rx_done) begin
            resp_data  <= from_rx;
            resp_valid <= 1'b1;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            r_state    <= ST_IDLE;
          end else if (w_expired) begin
            resp_timeout <= 1'b1;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_client.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_client                                          |
// | Description : Self-checking bench for alu_client with a transaction- |
// |               level reference model and randomized stimulus.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_client;

  localparam int TB_T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_a, req_b, req_op;
  logic       req_ready;
  logic [7:0] to_tx;
  logic       tx_start;
  logic       tx_done;
  logic       rx_done;
  logic [7:0] from_rx;
  logic       tick;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;
  logic       busy;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_last = 8'h00;

  alu_client #(
    .TIMEOUT_TICKS (16'd4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .to_tx        (to_tx),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .rx_done      (rx_done),
    .from_rx      (from_rx),
    .tick         (tick),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // response pulses must never coincide
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      assert (!(resp_valid === 1'b1 && resp_timeout === 1'b1)) else begin
        failures++;
        $error("FAIL resp_exclusive observed=%b%b expected=not both", resp_valid, resp_timeout);
      end
    end
  end

  // advance to the next negedge; tick carries random noise by default
  task automatic cyc();
    @(negedge clk);
    tick = 1'($urandom_range(0, 1));
  endtask

  // rx_mode: 0 random reply time, 1 never reply, 2 reply on the expiry
  // cycle, 3 reply promptly
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input int rx_mode, input logic [7:0] rx_byte, input bit stray);
    logic [7:0] bytes [3];
    int         d;
    int         ticks_seen;
    int         rx_at;
    int         c;
    bit         done, do_rx, do_tick, exp_v, exp_to;
    bytes[0] = a; bytes[1] = b; bytes[2] = op;
    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    cyc();
    req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_op = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      chk1("tx_start_pulse", tx_start, 1'b1);
      chk8("to_tx_byte", to_tx, bytes[i]);
      chk1("busy_high", busy, 1'b1);
      chk1("req_ready_busy", req_ready, 1'b0);
      d = $urandom_range(1, 4);
      for (int k = 0; k < d; k++) begin
        cyc();
        rx_done = 1'b0;
        chk1("tx_start_one_cycle", tx_start, 1'b0);
        chk8("to_tx_hold", to_tx, bytes[i]);
        chk1("req_ready_held_low", req_ready, 1'b0);
        if (stray) begin
          req_valid = 1'($urandom_range(0, 1));
          req_a = 8'hEE;
          if (i == 1 && k == 0) begin
            rx_done = 1'b1;
            from_rx = 8'h55;
          end
        end
      end
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0; rx_done = 1'b0; req_valid = 1'b0;
    end
    chk1("tx_start_none_in_wait_res", tx_start, 1'b0);
    chk1("busy_wait_res", busy, 1'b1);
    ticks_seen = 0; done = 0; exp_v = 0; exp_to = 0; c = 0;
    rx_at = $urandom_range(0, 12);
    while (!done && c < 100) begin
      do_tick = 1'($urandom_range(0, 1));
      case (rx_mode)
        0:       do_rx = (c == rx_at);
        2:       do_rx = (ticks_seen >= TB_T);
        3:       do_rx = (c == 1);
        default: do_rx = 1'b0;
      endcase
      tick = do_tick;
      rx_done = do_rx;
      from_rx = do_rx ? rx_byte : 8'($urandom);
      if (do_rx) exp_v = 1'b1;
      else if (ticks_seen >= TB_T) exp_to = 1'b1;
      ticks_seen += int'(do_tick);
      cyc();
      rx_done = 1'b0;
      chk1("resp_valid", resp_valid, exp_v);
      chk1("resp_timeout", resp_timeout, exp_to);
      if (exp_v || exp_to) begin
        done = 1'b1;
        if (exp_v) model_last = rx_byte;
        chk8("resp_data", resp_data, model_last);
        chk1("req_ready_after", req_ready, 1'b1);
        chk1("busy_after", busy, 1'b0);
        cyc();
        chk1("resp_valid_width", resp_valid, 1'b0);
        chk1("resp_timeout_width", resp_timeout, 1'b0);
      end
      c++;
    end
    if (!done) begin
      failures++;
      $error("FAIL wait_res_budget observed=no_response expected=response_within_100");
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    tx_done = 1'b0; rx_done = 1'b0; from_rx = '0; tick = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tx_start", tx_start, 1'b0);
    chk8("rst_to_tx", to_tx, 8'h00);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_timeout", resp_timeout, 1'b0);
    chk8("rst_resp_data", resp_data, 8'h00);
    reset = 1'b0;
    cyc();
    chk1("post_rst_tx_start", tx_start, 1'b0);

    // normal operation
    run_txn(8'h05, 8'h03, 8'h01, 3, 8'h08, 1'b0);
    // timeout with no reply
    run_txn(8'h10, 8'h20, 8'h02, 1, 8'h00, 1'b0);
    // reply lands on the expiry cycle
    run_txn(8'h0A, 8'h0B, 8'h03, 2, 8'hAA, 1'b0);
    // stray rx byte and overlapping requests while busy
    run_txn(8'h21, 8'h42, 8'h04, 3, 8'h63, 1'b1);

    // reset while waiting for operand B to finish
    req_valid = 1'b1; req_a = 8'h11; req_b = 8'h22; req_op = 8'h33;
    cyc();
    req_valid = 1'b0;
    chk8("abort_to_tx_a", to_tx, 8'h11);
    cyc();
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk8("abort_to_tx_b", to_tx, 8'h22);
    cyc();
    #2 reset = 1'b1;
    #1;
    chk1("async_rst_req_ready", req_ready, 1'b1);
    chk1("async_rst_busy", busy, 1'b0);
    chk8("async_rst_to_tx", to_tx, 8'h00);
    chk1("async_rst_tx_start", tx_start, 1'b0);
    chk8("async_rst_resp_data", resp_data, 8'h00);
    model_last = 8'h00;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk1("abort_no_tx_start", tx_start, 1'b0);
    chk1("abort_no_resp_valid", resp_valid, 1'b0);
    chk1("abort_no_resp_timeout", resp_timeout, 1'b0);
    run_txn(8'h77, 8'h88, 8'h99, 3, 8'h5A, 1'b0);

    // randomized transactions
    for (int n = 0; n < 30; n++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3),
              8'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin
        cyc();
        chk1("idle_gap_ready", req_ready, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
